// File: rtl/shift_sequencer.sv
// Purpose: command-driven controller for a bidirectional serial shift register.
// Latency: command accepted on edge T, shifts on edges T+1..T+len, response visible after edge T+len.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RESP until rsp_ready.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (cmd_dir, cmd_len, cmd_data)
//   sr_en, sr_dir, sr_d, sr_q        shifter control outputs and parallel readback
//   rsp_valid/rsp_ready, rsp_data    response handshake carrying the ejected bits
//   busy                             high while a command is shifting or its response is pending
module shift_sequencer #(
    parameter  int MSB = 4,
    localparam int CW  = $clog2(MSB + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_dir,
    input  logic [CW-1:0]  cmd_len,
    input  logic [MSB-1:0] cmd_data,
    output logic           sr_en,
    output logic           sr_dir,
    output logic           sr_d,
    input  logic [MSB-1:0] sr_q,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [MSB-1:0] rsp_data,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           dir_q,   dir_d;
    logic [CW-1:0]  len_q,   len_d;
    logic [CW-1:0]  idx_q,   idx_d;
    logic [MSB-1:0] data_q,  data_d;
    logic [MSB-1:0] rsp_q,   rsp_d;

    logic [CW-1:0]  len_clamped;
    logic [MSB-1:0] data_sh;
    logic [MSB-1:0] eject_vec;
    logic           eject_bit;

    // Lengths beyond the register width would just recirculate payload bits, so cap them.
    assign len_clamped = (cmd_len > CW'(MSB)) ? CW'(MSB) : cmd_len;

    // Shift-based selects keep the index width independent of the vector width.
    assign data_sh   = data_q >> idx_q;
    assign eject_bit = dir_q ? sr_q[0] : sr_q[MSB-1];
    assign eject_vec = {{(MSB-1){1'b0}}, eject_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

    // Outputs depend only on registered state; sr_en therefore drops as soon as reset
    // forces state_q back to IDLE.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        len_d     = len_q;
        idx_d     = idx_q;
        data_d    = data_q;
        rsp_d     = rsp_q;
        cmd_ready = 1'b0;
        sr_en     = 1'b0;
        sr_dir    = 1'b0;
        sr_d      = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    len_d   = len_clamped;
                    data_d  = cmd_data;
                    idx_d   = '0;
                    rsp_d   = '0;
                    state_d = (len_clamped == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                busy   = 1'b1;
                sr_en  = 1'b1;
                sr_dir = dir_q;
                sr_d   = data_sh[0];
                // Capture the bit leaving the shifter on this edge into slot idx.
                rsp_d  = rsp_q | (eject_vec << idx_q);
                idx_d  = idx_q + CW'(1);
                if ((idx_q + CW'(1)) == len_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: bench for shift_sequencer with a behavioural shift register and a response scoreboard.
// Latency: checks shift count and response timing against hand-computed values.
// Backpressure: exercises rsp_ready held low while a second command waits.
module tb_shift_sequencer;

    localparam int MSB = 4;
    localparam int CW  = $clog2(MSB + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_dir;
    logic [CW-1:0]  cmd_len;
    logic [MSB-1:0] cmd_data;
    logic           sr_en;
    logic           sr_dir;
    logic           sr_d;
    logic [MSB-1:0] sh_q;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [MSB-1:0] rsp_data;
    logic           busy;

    logic [MSB-1:0] sh_pre;
    logic           sh_load;

    int checks = 0;
    int errors = 0;
    int en_total = 0;

    logic [MSB-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_sequencer #(.MSB(MSB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .sr_en     (sr_en),
        .sr_dir    (sr_dir),
        .sr_d      (sr_d),
        .sr_q      (sh_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Controlled shifter: right ejects bit 0 and enters at MSB-1, left the opposite.
    always_ff @(posedge clk) begin
        if (sh_load) begin
            sh_q <= sh_pre;
        end else if (sr_en) begin
            sh_q <= sr_dir ? {sr_d, sh_q[MSB-1:1]} : {sh_q[MSB-2:0], sr_d};
        end
    end

    always @(negedge clk) begin
        if (sr_en) en_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_data %0h, expected no response", rsp_data);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic preload(input logic [MSB-1:0] v);
        @(posedge clk);
        #1 sh_pre = v;
        sh_load = 1'b1;
        @(posedge clk);
        #1 sh_load = 1'b0;
    endtask

    // Present a command and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic issue(input logic dir, input logic [CW-1:0] len, input logic [MSB-1:0] data);
        int n;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_data  = data;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept_timeout: got cmd_ready 0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Number of negedges after the accepting edge before rsp_valid first appears.
    task automatic wait_rsp(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: got rsp_valid 0, expected 1");
                break;
            end
        end
    endtask

    task automatic run_case(input string name, input logic dir, input logic [CW-1:0] len,
                            input logic [MSB-1:0] data, input logic [MSB-1:0] exp_rsp,
                            input int exp_shifts, input logic [MSB-1:0] exp_sr);
        int e0;
        int n;
        preload(4'b1011);
        e0 = en_total;
        exp_q.push_back(exp_rsp);
        issue(dir, len, data);
        wait_rsp(n);
        check({name, "_latency"}, 32'(n), 32'(exp_shifts));
        @(posedge clk);
        #1;
        check({name, "_sr_en_cycles"}, 32'(en_total - e0), 32'(exp_shifts));
        check({name, "_sr_q"}, 32'(sh_q), 32'(exp_sr));
        check({name, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        int e0;
        int seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        sh_load   = 1'b0;
        sh_pre    = '0;

        #12;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_sr_en", 32'(sr_en), 32'd0);
        check("reset_sr_dir_d", 32'({sr_dir, sr_d}), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_case("right4", 1'b1, 3'd4, 4'b0110, 4'b1011, 4, 4'b0110);
        run_case("left4",  1'b0, 3'd4, 4'b0110, 4'b1101, 4, 4'b0110);
        run_case("right2", 1'b1, 3'd2, 4'b0011, 4'b0011, 2, 4'b1110);
        run_case("len0",   1'b1, 3'd0, 4'b0110, 4'b0000, 0, 4'b1011);
        run_case("len7",   1'b1, 3'd7, 4'b0110, 4'b1011, 4, 4'b0110);

        // Backpressure: response held while a second command waits on cmd_valid.
        preload(4'b1011);
        rsp_ready = 1'b0;
        exp_q.push_back(4'b0011);
        issue(1'b1, 3'd2, 4'b0011);
        wait_rsp(n);
        check("bp_latency", 32'(n), 32'd2);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_len   = 3'd1;
        cmd_data  = 4'b0001;
        exp_q.push_back(4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h3);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_in_resp", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_after_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(n);
        check("bp_second_latency", 32'(n), 32'd1);
        @(posedge clk);
        #1;
        check("bp_second_sr_q", 32'(sh_q), 32'b1101);

        // Reset after the second shift of a length-4 command.
        preload(4'b1011);
        issue(1'b1, 3'd4, 4'b0110);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_sr_en", 32'(sr_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_sr_q_two_shifts", 32'(sh_q), 32'b1010);
        @(posedge clk);
        #1 rst = 1'b0;
        e0 = en_total;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        check("rst_no_shift", 32'(en_total - e0), 32'd0);
        check("rst_ready_after", 32'(cmd_ready), 32'd1);
        run_case("post_rst", 1'b1, 3'd4, 4'b0110, 4'b1011, 4, 4'b0110);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
